// File: rtl/uart_pkg.sv
// Definitions shared by the transmit- and receive-side UART byte queues.
package uart_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_WAIT = 2'b10
    } q_state_e;

endpackage

// File: rtl/uart_tx_queue_if.sv
// Processor-side push port plus Transmitter hand-off signals of the TX byte queue.
interface uart_tx_queue_if #(parameter int ADDR_W = 4);
    import uart_pkg::*;

    logic              WR_EN;
    logic [DATA_W-1:0] WR_DATA;
    logic              FULL;
    logic              EMPTY;
    logic [ADDR_W:0]   COUNT;
    logic              OVERFLOW;
    logic [DATA_W-1:0] LINEOUT;
    logic              TXSTART;
    logic              TXDONE;
    logic              BUSY;

    modport master (
        output WR_EN, WR_DATA, TXDONE,
        input  FULL, EMPTY, COUNT, OVERFLOW, LINEOUT, TXSTART, BUSY
    );

    modport slave (
        input  WR_EN, WR_DATA, TXDONE,
        output FULL, EMPTY, COUNT, OVERFLOW, LINEOUT, TXSTART, BUSY
    );

endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock byte FIFO with occupancy count and one-cycle overflow pulse.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] dout_o,
    output logic [ADDR_W:0]   count_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              overflow_o
);

    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   CNT_MAX = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              accept;
    logic              take;

    assign full_o     = (count_q == CNT_MAX);
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign overflow_o = overflow_q;
    assign dout_o     = mem_q[rd_ptr_q];

    // FULL comes from the registered count, so a same-edge pop never frees room for a write.
    assign accept = push_i && !full_o;
    assign take   = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d   = accept ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d   = take ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        overflow_d = push_i && full_o;
        unique case ({accept, take})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: storage is deliberately not reset; pointers and count alone decide what is valid.
    always_ff @(posedge CLOCK) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/uart_tx_queue.sv
// TX byte queue: buffers processor writes and hands them to the UART Transmitter one frame at a time.
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input logic            CLOCK,
    input logic            RESET,
    uart_tx_queue_if.slave q
);

    q_state_e          state_q, state_d;
    logic [DATA_W-1:0] lineout_q, lineout_d;
    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_empty;
    logic              pop;
    logic              txstart;

    uart_sync_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .push_i     (q.WR_EN),
        .pop_i      (pop),
        .din_i      (q.WR_DATA),
        .dout_o     (fifo_dout),
        .count_o    (q.COUNT),
        .full_o     (q.FULL),
        .empty_o    (fifo_empty),
        .overflow_o (q.OVERFLOW)
    );

    // NOTE: every signal gets a default first so no path through the case can infer a latch.
    always_comb begin
        state_d   = state_q;
        lineout_d = lineout_q;
        pop       = 1'b0;
        txstart   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    lineout_d = fifo_dout;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                txstart = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (q.TXDONE) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            lineout_q <= '0;
        end else begin
            state_q   <= state_d;
            lineout_q <= lineout_d;
        end
    end

    assign q.EMPTY   = fifo_empty;
    assign q.LINEOUT = lineout_q;
    assign q.TXSTART = txstart;
    assign q.BUSY    = (state_q != ST_IDLE);

endmodule

// File: doc/uart_tx_queue.md
Name: uart_tx_queue

Overview:
Byte queue placed directly upstream of the UART Transmitter. The processor side pushes bytes with a one-cycle write strobe. The block buffers them in a FIFO and feeds them one at a time to the Transmitter. For each byte it presents the byte on LINEOUT, pulses TXSTART for one cycle, then waits for the Transmitter's DONE before issuing the next byte. This frees the processor from pacing writes to the baud rate.

Parameters:
DEPTH, 16, number of byte entries; power of two, minimum 2
ADDR_W, 4, log2(DEPTH); pointer width
DATA_W, 8, byte width; fixed at 8 to match the Transmitter

Ports:
CLOCK  input  1  system clock, shared with the Transmitter and BaudSync
RESET  input  1  asynchronous, active-high reset
WR_EN  input  1  push strobe; one byte per cycle while high
WR_DATA  input  8  byte to push
FULL  output  1  high when COUNT == DEPTH
EMPTY  output  1  high when COUNT == 0
COUNT  output  ADDR_W+1  bytes stored; excludes the byte currently in flight
OVERFLOW  output  1  one-cycle pulse when a write is dropped
LINEOUT  output  8  byte for the Transmitter; connects to its LINEIN
TXSTART  output  1  one-cycle start pulse; connects to the Transmitter's TXSTART
TXDONE  input  1  connects to the Transmitter's DONE
BUSY  output  1  high while a byte is handed off or in flight (state != IDLE)

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE; read and write pointers = 0; COUNT = 0.
  - LINEOUT = 8'h00; TXSTART = 0; OVERFLOW = 0; EMPTY = 1; FULL = 0; BUSY = 0.
  - Stored contents are discarded.
  - The Transmitter must share the same RESET, so a reset mid-frame aborts both blocks together.
- Storage: register array with pointers of ADDR_W bits that wrap naturally from DEPTH-1 to 0.
- Write rules:
  - A write is accepted when WR_EN && !FULL, with FULL evaluated from the registered COUNT.
  - WR_DATA goes to mem[wr_ptr]; wr_ptr increments.
  - WR_EN while FULL: byte dropped; pointers and COUNT unchanged; OVERFLOW high for the next cycle only.
- Pop rule: FSM pops in IDLE when !EMPTY.
- COUNT update per edge:
  - +1 on accepted write only.
  - -1 on pop only.
  - Unchanged when both occur on the same edge.
- A write while FULL is rejected even if a pop happens on the same edge.
- FSM, registered state, encodings IDLE=2'b00, LOAD=2'b01, WAIT=2'b10:
  - IDLE: if !EMPTY, LINEOUT <= mem[rd_ptr], rd_ptr++, COUNT--, go to LOAD. Otherwise stay.
  - LOAD: TXSTART = 1, decoded combinationally from state, so high for exactly one clock. Go to WAIT unconditionally.
  - WAIT: TXSTART = 0. On TXDONE go to IDLE, otherwise stay.
  - 2'b11 is illegal; recover to IDLE on the next edge.
- TXDONE outside WAIT is ignored.
- LINEOUT holds its value from the pop until the next pop. It stays stable while TXSTART is high.
- Latency:
  - Write accepted at edge k into an empty queue with FSM in IDLE: pop at edge k+1.
  - TXSTART high between edges k+1 and k+2; the Transmitter captures at edge k+2.
- Back-to-back bytes: when TXDONE is seen at edge t, the next pop is at edge t+1 and the next TXSTART is between t+1 and t+2.
- Throughput: one byte per frame time plus 2 clocks.
- TXSTART is never high while the Transmitter is outside IDLE, because the handshake waits for DONE. This rule is what prevents a retrigger after STOP.

Decomposition:
- Shared package uart_pkg:
  - DATA_W = 8.
  - Queue FSM state encodings IDLE/LOAD/WAIT.
  - Shared with the Receiver-side queue.
- One sub-module: uart_sync_fifo.
  - Contains the memory array, pointers, COUNT, FULL, EMPTY and overflow logic.
  - Ports: push, pop, din, dout.
- uart_tx_queue instantiates uart_sync_fifo and adds the hand-off FSM.

Test Plan:
1. Reset check: assert RESET mid-WAIT with COUNT=3 -> immediately EMPTY=1, COUNT=0, TXSTART=0, BUSY=0, LINEOUT=8'h00; no TXSTART after release.
2. Single byte: push 8'hB6 into an empty queue -> TXSTART high for exactly one cycle, 2 edges after the write, with LINEOUT=8'hB6; the Transmitter's DATA serialises 0,0,1,1,0,1,1,0,1 bit-by-tick; BUSY drops one cycle after DONE.
3. Burst ordering: push 8'hB6, 8'hA2, 8'h55 on consecutive cycles -> COUNT peaks at 2; three frames go out in that order; exactly three TXSTART pulses, each 1 cycle after the previous DONE.
4. Full/overflow: hold TXDONE low and push 18 bytes (DEPTH=16) -> 1 popped, 16 stored; FULL=1; OVERFLOW pulses once for the 18th byte; that byte is never transmitted.
5. Simultaneous push/pop: with COUNT=1 and FSM in IDLE, push on the same edge as the pop -> COUNT stays 1; data order preserved.
6. Wrap-around: stream 40 bytes 8'h00..8'h27 through the queue with a real Transmitter -> all 40 bytes received in order across pointer wrap; no OVERFLOW.
